prescaled_decade_counter: RTL and testbench
===========================================

// Module: prescaled_decade_counter
// PURPOSE
//  Programmable-prescaler decade counter: successor to the fixed one-digit
//  seconds/digit counter on the TT user tile. A CNT_W-bit prescaler compares
//  against a shifted run-time value. On each terminal count it advances a
//  cascade of DIGITS base-MODULO digits, with carry between digits.
//  Drives 7-seg/LED logic and exposes prescaler low bits on uio.
// PARAMETERS
//  CNT_W     24  prescaler width (bits)
//  CMP_W      8  width of run-time compare input
//  CMP_SHIFT 10  compare = {zeros, cmp_in, CMP_SHIFT'b0}; CMP_W+CMP_SHIFT <= CNT_W
//  DIGITS     2  number of cascaded digits (1..8)
//  MODULO    10  digit modulus (2..16); digits are 4 bits wide
// PORTS
//  clk       in   1          clock
//  reset     in   1          synchronous, active-high reset
//  en        in   1          count enable; low = hold all state
//  clr       in   1          synchronous clear of prescaler and digits
//  cmp_in    in   CMP_W      prescaler compare value (sampled every cycle)
//  tick      out  1          one-cycle pulse per prescaler terminal count
//  wrap      out  1          one-cycle pulse when the whole cascade rolls over
//  digits    out  4*DIGITS   packed digits; digit 0 in [3:0]
//  pre_lo    out  8          prescaler bits [7:0] (debug/uio)
// BEHAVIOUR
//  - Reset: the prescaler, all digits, tick and wrap are 0.
//    pre_lo is 0. Reset has priority over everything.
//  - Priority per edge: reset > clr > en. clr=1 gives the same state as reset.
//  - en=0, no clr: prescaler and digits hold; tick and wrap are driven 0.
//  - Terminal: en=1 and cnt >= compare. The >= compare makes a lowered cmp_in
//    mid-count terminate on the next edge, never a 2^CNT_W wrap.
//    - On a terminal edge: cnt<=0 and tick<=1.
//    - On a non-terminal edge: cnt<=cnt+1 and tick<=0.
//    - Tick period is compare+1 cycles. compare==0 gives tick every cycle.
//  - tick and wrap are registered. They are high in the cycle after the edge
//    that updated digits, so digits are already the new value when tick is seen.
//  - Digit i advances on a terminal edge when every digit j<i == MODULO-1.
//    Digit 0 advances on every terminal edge.
//  - A digit at MODULO-1 advances to 0. Digits never hold a value >= MODULO.
//  - wrap<=1 on a terminal edge when all digits == MODULO-1 (cascade -> all 0).
//    Otherwise wrap<=0.
//  - Arithmetic is unsigned. compare is zero-extended to CNT_W.
//  - There is no counter overflow path: cnt never exceeds max(compare, previous cnt).
// CONFIGURATION
//  - `define PRESCALED_DECADE_COUNTER_DOWN_EN adds input port dir (1 bit).
//    - dir=1: digits count down; 0 -> MODULO-1. Digit i borrows when all lower
//      digits == 0. wrap fires when all digits are 0 at a terminal edge
//      (cascade -> all MODULO-1).
//    - dir=0: up-count as above.
//    - dir is sampled per edge. A change takes effect on the next terminal edge,
//      with no glitch in digits.
//  - Macro undefined: no dir port; up-count only. Logic is identical to the
//    macro defined with dir tied to 0.
// TESTING  (bench uses CMP_SHIFT=0, DIGITS=2, MODULO=10 unless stated)
//  - Reset: cmp_in=3, reset 2 cycles, then en=1.
//    -> tick high every 4th cycle. digits 0x00->0x01->0x02.
//    -> pre_lo sequence 0,1,2,3,0.
//  - Cascade: cmp_in=0, en=1, run 100 cycles.
//    -> digits steps 0x09->0x10 at the 10th tick.
//    -> at the 100th tick: 0x99->0x00, with wrap=1 for exactly that 1 cycle.
//  - Hold/clear: cmp_in=5, drop en at cnt=3 for 10 cycles.
//    -> pre_lo stays 3 and tick=0. Raise en: tick 3 cycles later.
//    -> clr=1 with en=1 -> next cycle digits=0, pre_lo=0, tick=0.
//  - Compare change: cmp_in=200, at cnt=50 set cmp_in=10.
//    -> terminal on the next edge (tick next cycle), then period 11 cycles.
//  - Shift: CMP_SHIFT=10, cmp_in=1.
//    -> tick period 1025 cycles. cmp_in=0 -> tick every cycle.
//  - DOWN_EN: dir=1 from reset, cmp_in=0.
//    -> first tick gives digits 0x99 with wrap=1, then 0x98.
//    -> switch dir=0 at 0x90 -> next 0x91.

Source files
------------

// File: rtl/prescaled_decade_counter.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_decade_counter
// Brief    : Run-time programmable prescaler driving a cascade of base-MODULO
//            digits. Optional down-count via PRESCALED_DECADE_COUNTER_DOWN_EN.
// Revision : 1.0
// ============================================================================
module prescaled_decade_counter #(
  parameter int CNT_W     = 24,
  parameter int CMP_W     = 8,
  parameter int CMP_SHIFT = 10,
  parameter int DIGITS    = 2,
  parameter int MODULO    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [CMP_W-1:0]    cmp_in_i,
`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
  input  logic                dir_i,
`endif
  output logic                tick_o,
  output logic                wrap_o,
  output logic [4*DIGITS-1:0] digits_o,
  output logic [7:0]          pre_lo_o
);

  localparam logic [3:0] c_dig_max = 4'(MODULO - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;

  logic [CNT_W-1:0]    cmp_w;
  logic                terminal;
  logic                down;
  logic                carry;
  logic [3:0]          dig;

`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
  assign down = dir_i;
`else
  assign down = 1'b0;
`endif

  assign cmp_w = CNT_W'(cmp_in_i) << CMP_SHIFT;

  // >= rather than == so a lowered compare value terminates immediately.
  assign terminal = en_i && (cnt_q >= cmp_w);

  always_comb begin
    cnt_d    = cnt_q;
    digits_d = digits_q;
    carry    = terminal;
    dig      = 4'd0;
    if (terminal) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Ripple the carry/borrow from digit 0 upward; carry out of the top is wrap.
    for (int i = 0; i < DIGITS; i++) begin
      dig = digits_q[4*i +: 4];
      if (carry) begin
        if (down) begin
          digits_d[4*i +: 4] = (dig == 4'd0) ? c_dig_max : dig - 4'd1;
        end else begin
          digits_d[4*i +: 4] = (dig >= c_dig_max) ? 4'd0 : dig + 4'd1;
        end
      end
      carry = carry && (down ? (dig == 4'd0) : (dig == c_dig_max));
    end
    tick_d = terminal;
    wrap_d = carry;
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q    <= '0;
      digits_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign tick_o   = tick_q;
  assign wrap_o   = wrap_q;
  assign digits_o = digits_q;
  assign pre_lo_o = 8'(cnt_q);

endmodule
`default_nettype wire

// File: tb/tb_prescaled_decade_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prescaled_decade_counter
// Brief    : Directed self-checking bench; second instance covers CMP_SHIFT=10.
// Revision : 1.0
// ============================================================================
module tb_prescaled_decade_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic [7:0] cmp;
  logic [7:0] cmp_s;
  logic       tick, wrap, tick_s, wrap_s;
  logic [7:0] digits, digits_s;
  logic [7:0] pre_lo, pre_lo_s;
`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
  logic       dir;
  logic       dir_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  prescaled_decade_counter #(
    .CNT_W(24), .CMP_W(8), .CMP_SHIFT(0), .DIGITS(2), .MODULO(10)
  ) dut (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr), .cmp_in_i(cmp),
`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
    .dir_i(dir),
`endif
    .tick_o(tick), .wrap_o(wrap), .digits_o(digits), .pre_lo_o(pre_lo)
  );

  prescaled_decade_counter #(
    .CNT_W(24), .CMP_W(8), .CMP_SHIFT(10), .DIGITS(2), .MODULO(10)
  ) dut_s (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr), .cmp_in_i(cmp_s),
`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
    .dir_i(dir_s),
`endif
    .tick_o(tick_s), .wrap_o(wrap_s), .digits_o(digits_s), .pre_lo_o(pre_lo_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_d;
    cmp = 8'd3;
    do_reset();
    n_checks++;
    if (tick !== 1'b0 || wrap !== 1'b0 || digits !== 8'h00 || pre_lo !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: tick=%b wrap=%b digits=%h pre_lo=%0d expected 0/0/00/0",
               tick, wrap, digits, pre_lo);
    end
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_d = 8'(k / 4);
      n_checks++;
      if (tick !== (k % 4 == 0) || pre_lo !== 8'(k % 4) || digits !== exp_d || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_seq edge %0d: tick=%b pre_lo=%0d digits=%h wrap=%b expected %b/%0d/%h/0",
                 k, tick, pre_lo, digits, wrap, (k % 4 == 0), k % 4, exp_d);
      end
    end
  endtask

  task automatic test_cascade();
    logic [7:0] exp_d;
    logic       exp_w;
    cmp = 8'd0;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      step();
      exp_d = {4'((k % 100) / 10), 4'(k % 10)};
      exp_w = (k == 100);
      n_checks++;
      if (tick !== 1'b1 || digits !== exp_d || wrap !== exp_w) begin
        n_errors++;
        $display("FAIL cascade tick %0d: tick=%b digits=%h wrap=%b expected 1/%h/%b",
                 k, tick, digits, wrap, exp_d, exp_w);
      end
    end
  endtask

  task automatic test_hold_clear();
    cmp = 8'd5;
    do_reset();
    en = 1'b1;
    step(); step(); step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (pre_lo !== 8'd3 || tick !== 1'b0 || digits !== 8'h00) begin
        n_errors++;
        $display("FAIL hold cycle %0d: pre_lo=%0d tick=%b digits=%h expected 3/0/00",
                 k, pre_lo, tick, digits);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (tick !== (k == 3) || pre_lo !== ((k == 3) ? 8'd0 : 8'(3 + k))) begin
        n_errors++;
        $display("FAIL resume edge %0d: tick=%b pre_lo=%0d expected %b/%0d",
                 k, tick, pre_lo, (k == 3), (k == 3) ? 0 : 3 + k);
      end
    end
    n_checks++;
    if (digits !== 8'h01) begin
      n_errors++;
      $display("FAIL resume_digits: digits=%h expected 01", digits);
    end
    for (int k = 0; k < 5; k++) step();
    // cnt now 5: without clr the next edge would be terminal.
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++;
    if (digits !== 8'h00 || pre_lo !== 8'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL clear: digits=%h pre_lo=%0d tick=%b wrap=%b expected 00/0/0/0",
               digits, pre_lo, tick, wrap);
    end
  endtask

  task automatic test_cmp_change();
    cmp = 8'd200;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 50; k++) step();
    n_checks++;
    if (pre_lo !== 8'd50 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL cmp_pre: pre_lo=%0d tick=%b expected 50/0", pre_lo, tick);
    end
    cmp = 8'd10;
    step();
    n_checks++;
    if (tick !== 1'b1 || pre_lo !== 8'd0 || digits !== 8'h01) begin
      n_errors++;
      $display("FAIL cmp_lowered: tick=%b pre_lo=%0d digits=%h expected 1/0/01",
               tick, pre_lo, digits);
    end
    for (int k = 1; k <= 22; k++) begin
      step();
      n_checks++;
      if (tick !== (k % 11 == 0) || pre_lo !== 8'(k % 11)) begin
        n_errors++;
        $display("FAIL cmp_period edge %0d: tick=%b pre_lo=%0d expected %b/%0d",
                 k, tick, pre_lo, (k % 11 == 0), k % 11);
      end
    end
  endtask

  task automatic test_shift();
    int edges;
    cmp_s = 8'd1;
    do_reset();
    en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      edges = 0;
      do begin
        step();
        edges++;
      end while (tick_s !== 1'b1 && edges < 2000);
      n_checks++;
      if (edges != 1025) begin
        n_errors++;
        $display("FAIL shift_period %0d: edges=%0d expected 1025", p, edges);
      end
    end
    cmp_s = 8'd0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (tick_s !== 1'b1) begin
        n_errors++;
        $display("FAIL shift_zero edge %0d: tick=%b expected 1", k, tick_s);
      end
    end
  endtask

`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
  task automatic test_down();
    logic [7:0] exp_d;
    dir = 1'b1;
    cmp = 8'd0;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_d = {4'd9, 4'(10 - k)};
      n_checks++;
      if (digits !== exp_d || wrap !== (k == 1) || tick !== 1'b1) begin
        n_errors++;
        $display("FAIL down edge %0d: digits=%h wrap=%b tick=%b expected %h/%b/1",
                 k, digits, wrap, tick, exp_d, (k == 1));
      end
    end
    dir = 1'b0;
    step();
    n_checks++;
    if (digits !== 8'h91 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL down_to_up: digits=%h wrap=%b expected 91/0", digits, wrap);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    cmp   = 8'd0;
    cmp_s = 8'd0;
`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
    dir   = 1'b0;
    dir_s = 1'b0;
`endif
    test_reset();
    test_cascade();
    test_hold_clear();
    test_cmp_change();
    test_shift();
`ifdef PRESCALED_DECADE_COUNTER_DOWN_EN
    test_down();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
